// File: rtl/add16_seq.sv
// rtl/add16_seq.sv - 16-bit add/subtract sequencer driving a shared 8-bit adder
//
// Purpose: accepts 16-bit operands, runs the low byte and then the high byte
// through an external 8-bit adder, chains the low-byte carry into the high
// byte, and latches the 16-bit result with carry, overflow and zero flags.
//
// Parameters:
//   ADD_WAIT - extra settle cycles each byte is held on the adder (0..15)
//
// Optional feature macro: ADD16_SUB_EN (adds the sub port and subtraction)
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   start          - request an operation (sampled when not busy)
//   a_in, b_in     - 16-bit operands
//   ci_in          - carry-in to bit 0
//   sub            - subtract select (ADD16_SUB_EN only)
//   busy           - operation in progress (LO/HI)
//   done           - one-cycle completion pulse
//   sum, co, of, zf- result register and flags
//   add_a, add_b   - adder operands
//   add_ci         - adder carry-in
//   add_s, add_co  - adder sum and carry-out
module add16_seq #(
  parameter int unsigned ADD_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic        ci_in,
`ifdef ADD16_SUB_EN
  input  logic        sub,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        co,
  output logic        of,
  output logic        zf,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_ci,
  input  logic [7:0]  add_s,
  input  logic        add_co
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(ADD_WAIT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;        // effective B (already inverted for subtract)
  logic        c0_q, c0_d;
  logic        cm_q, cm_d;      // carry from low byte into high byte
  logic [7:0]  lo_q, lo_d;      // low-byte shadow, kept off sum until HI capture
  logic [15:0] sum_q, sum_d;
  logic        co_q, co_d;
  logic        of_q, of_d;
  logic        zf_q, zf_d;
  logic [7:0]  add_a_q, add_a_d;
  logic [7:0]  add_b_q, add_b_d;
  logic        add_ci_q, add_ci_d;

  logic        sub_sel;
  logic [15:0] beff_in;
  logic        c0_in;
  logic [15:0] sum_new;

`ifdef ADD16_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Subtraction is A + ~B + 1; ci_in is ignored when subtracting.
  assign beff_in = sub_sel ? ~b_in : b_in;
  assign c0_in   = sub_sel | ci_in;
  assign sum_new = {add_s, lo_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c0_d     = c0_q;
    cm_d     = cm_q;
    lo_d     = lo_q;
    sum_d    = sum_q;
    co_d     = co_q;
    of_d     = of_q;
    zf_d     = zf_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    add_ci_d = add_ci_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = beff_in;
          c0_d     = c0_in;
          cnt_d    = WAIT_LD;
          state_d  = S_LO;
          // Adder inputs are registered, so load the low byte alongside the
          // state change to have it present for the whole LO window.
          add_a_d  = a_in[7:0];
          add_b_d  = beff_in[7:0];
          add_ci_d = c0_in;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LO: begin
        if (cnt_q == 4'd0) begin
          lo_d     = add_s;
          cm_d     = add_co;
          cnt_d    = WAIT_LD;
          state_d  = S_HI;
          add_a_d  = a_q[15:8];
          add_b_d  = b_q[15:8];
          add_ci_d = add_co;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_HI: begin
        if (cnt_q == 4'd0) begin
          sum_d    = sum_new;
          co_d     = add_co;
          of_d     = (a_q[15] ~^ b_q[15]) & (add_s[7] ^ a_q[15]);
          zf_d     = (sum_new == 16'd0);
          state_d  = S_DONE;
          add_a_d  = 8'd0;
          add_b_d  = 8'd0;
          add_ci_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      c0_q     <= 1'b0;
      cm_q     <= 1'b0;
      lo_q     <= 8'd0;
      sum_q    <= 16'd0;
      co_q     <= 1'b0;
      of_q     <= 1'b0;
      zf_q     <= 1'b0;
      add_a_q  <= 8'd0;
      add_b_q  <= 8'd0;
      add_ci_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c0_q     <= c0_d;
      cm_q     <= cm_d;
      lo_q     <= lo_d;
      sum_q    <= sum_d;
      co_q     <= co_d;
      of_q     <= of_d;
      zf_q     <= zf_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      add_ci_q <= add_ci_d;
    end
  end

  assign busy   = (state_q == S_LO) || (state_q == S_HI);
  assign done   = (state_q == S_DONE);
  assign sum    = sum_q;
  assign co     = co_q;
  assign of     = of_q;
  assign zf     = zf_q;
  assign add_a  = add_a_q;
  assign add_b  = add_b_q;
  assign add_ci = add_ci_q;

endmodule

// File: tb/tb_add16_seq.sv
// tb/tb_add16_seq.sv - self-checking bench for add16_seq (ADD_WAIT 0 and 2)
module tb_add16_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start2;
  logic [15:0] a_in, b_in;
  logic        ci_in, sub;

  logic        busy0, done0, co0, of0, zf0, add_ci0, add_co0;
  logic [15:0] sum0;
  logic [7:0]  add_a0, add_b0, add_s0;
  logic        busy2, done2, co2, of2, zf2, add_ci2, add_co2;
  logic [15:0] sum2;
  logic [7:0]  add_a2, add_b2, add_s2;

  // Behavioural 8-bit adders on each instance's adder port
  assign {add_co0, add_s0} = 9'(add_a0) + 9'(add_b0) + 9'(add_ci0);
  assign {add_co2, add_s2} = 9'(add_a2) + 9'(add_b2) + 9'(add_ci2);

  add16_seq #(.ADD_WAIT(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a_in(a_in), .b_in(b_in), .ci_in(ci_in),
`ifdef ADD16_SUB_EN
    .sub(sub),
`endif
    .busy(busy0), .done(done0), .sum(sum0), .co(co0), .of(of0), .zf(zf0),
    .add_a(add_a0), .add_b(add_b0), .add_ci(add_ci0), .add_s(add_s0), .add_co(add_co0)
  );

  add16_seq #(.ADD_WAIT(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a_in), .b_in(b_in), .ci_in(ci_in),
`ifdef ADD16_SUB_EN
    .sub(sub),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .co(co2), .of(of2), .zf(zf2),
    .add_a(add_a2), .add_b(add_b2), .add_ci(add_ci2), .add_s(add_s2), .add_co(add_co2)
  );

  logic        sel2;
  logic        busy_m, done_m, co_m, of_m, zf_m, add_ci_m, add_co_m;
  logic [15:0] sum_m;
  logic [7:0]  add_a_m, add_b_m;

  always_comb begin
    if (sel2) begin
      busy_m = busy2; done_m = done2; sum_m = sum2; co_m = co2; of_m = of2; zf_m = zf2;
      add_a_m = add_a2; add_b_m = add_b2; add_ci_m = add_ci2; add_co_m = add_co2;
    end else begin
      busy_m = busy0; done_m = done0; sum_m = sum0; co_m = co0; of_m = of0; zf_m = zf0;
      add_a_m = add_a0; add_b_m = add_b0; add_ci_m = add_ci0; add_co_m = add_co0;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] prev_sum0 = 16'd0;
  logic [15:0] prev_sum2 = 16'd0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, signed range test for overflow
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                       output logic [15:0] s, output logic c, output logic v, output logic z,
                       output logic [15:0] beff, output logic c0, output logic cm);
    logic [16:0] r;
    int sa, sbv, sv;
    beff = sb ? ~b : b;
    c0   = sb ? 1'b1 : ci;
    r    = 17'(a) + 17'(beff) + 17'(c0);
    s    = r[15:0];
    c    = r[16];
    sa   = int'($signed(a));
    sbv  = int'($signed(beff));
    sv   = sa + sbv + int'(c0);
    v    = (sv > 32767) || (sv < -32768);
    z    = (s == 16'd0);
    cm   = ((int'(a[7:0]) + int'(beff[7:0]) + int'(c0)) > 255);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 16'(busy_m), 16'd0);
    chk({tag, ".done"}, 16'(done_m), 16'd0);
    chk({tag, ".sum"}, sum_m, 16'd0);
    chk({tag, ".co"}, 16'(co_m), 16'd0);
    chk({tag, ".of"}, 16'(of_m), 16'd0);
    chk({tag, ".zf"}, 16'(zf_m), 16'd0);
    chk({tag, ".add_a"}, 16'(add_a_m), 16'd0);
    chk({tag, ".add_b"}, 16'(add_b_m), 16'd0);
    chk({tag, ".add_ci"}, 16'(add_ci_m), 16'd0);
  endtask

  // One operation on the selected instance; poke pulses start during LO
  task automatic run_op(input logic use2, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb_req, input logic poke, input string tag);
    logic [15:0] s, beff, prev;
    logic c, v, z, c0, cm, sb;
    int w;
    w = use2 ? 2 : 0;
`ifdef ADD16_SUB_EN
    sb = sb_req;
`else
    sb = 1'b0;
`endif
    model(a, b, ci, sb, s, c, v, z, beff, c0, cm);
    prev = use2 ? prev_sum2 : prev_sum0;
    @(negedge clk);
    sel2 = use2; a_in = a; b_in = b; ci_in = ci; sub = sb_req;
    if (use2) start2 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start2 = 1'b0;
    for (int k = 0; k <= w; k++) begin
      chk({tag, ".lo_busy"}, 16'(busy_m), 16'd1);
      chk({tag, ".lo_done"}, 16'(done_m), 16'd0);
      chk({tag, ".lo_a"}, 16'(add_a_m), 16'(a[7:0]));
      chk({tag, ".lo_b"}, 16'(add_b_m), 16'(beff[7:0]));
      chk({tag, ".lo_ci"}, 16'(add_ci_m), 16'(c0));
      chk({tag, ".lo_co"}, 16'(add_co_m), 16'(cm));
      chk({tag, ".lo_sum_hold"}, sum_m, prev);
      if (poke && k == 0) begin
        a_in = ~a; b_in = ~b;
        if (use2) start2 = 1'b1; else start0 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0;
    end
    for (int k = 0; k <= w; k++) begin
      chk({tag, ".hi_busy"}, 16'(busy_m), 16'd1);
      chk({tag, ".hi_done"}, 16'(done_m), 16'd0);
      chk({tag, ".hi_a"}, 16'(add_a_m), 16'(a[15:8]));
      chk({tag, ".hi_b"}, 16'(add_b_m), 16'(beff[15:8]));
      chk({tag, ".hi_ci"}, 16'(add_ci_m), 16'(cm));
      chk({tag, ".hi_sum_hold"}, sum_m, prev);
      @(negedge clk);
    end
    chk({tag, ".done"}, 16'(done_m), 16'd1);
    chk({tag, ".d_busy"}, 16'(busy_m), 16'd0);
    chk({tag, ".sum"}, sum_m, s);
    chk({tag, ".co"}, 16'(co_m), 16'(c));
    chk({tag, ".of"}, 16'(of_m), 16'(v));
    chk({tag, ".zf"}, 16'(zf_m), 16'(z));
    chk({tag, ".d_add_a"}, 16'(add_a_m), 16'd0);
    chk({tag, ".d_add_ci"}, 16'(add_ci_m), 16'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, ".post_done"}, 16'(done_m), 16'd0);
      chk({tag, ".post_busy"}, 16'(busy_m), 16'd0);
      chk({tag, ".post_sum"}, sum_m, s);
    end
    if (use2) prev_sum2 = s; else prev_sum0 = s;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] s1, s2, bf;
    logic c, v, z, c0, cm;
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; sel2 = 1'b0;
    a_in = 16'd0; b_in = 16'd0; ci_in = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    sel2 = 1'b0; #1 chk_zero("reset_u0");
    sel2 = 1'b1; #1 chk_zero("reset_u2");
    rst = 1'b0;

    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "carry_chain");
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "wrap_zero");
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "pos_ovf");
    run_op(1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, "ci_in");
`ifdef ADD16_SUB_EN
    run_op(1'b0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, "sub_borrow");
    run_op(1'b0, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, "sub_ovf");
`endif
    run_op(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, "wait2");
    run_op(1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b1, "wait2_ignore_start");
    run_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1, "ignore_start");

    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rand_w0");
      run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rand_w2");
    end

    // Back-to-back: start held high through DONE on the ADD_WAIT=0 instance
    model(16'h1111, 16'h2222, 1'b0, 1'b0, s1, c, v, z, bf, c0, cm);
    model(16'h4000, 16'h0123, 1'b1, 1'b0, s2, c, v, z, bf, c0, cm);
    @(negedge clk);
    sel2 = 1'b0; sub = 1'b0; a_in = 16'h1111; b_in = 16'h2222; ci_in = 1'b0; start0 = 1'b1;
    @(negedge clk); chk("b2b.t1_busy", 16'(busy0), 16'd1);
    @(negedge clk); chk("b2b.t2_done", 16'(done0), 16'd0);
    @(negedge clk); chk("b2b.t3_done", 16'(done0), 16'd1);
    chk("b2b.sum1", sum0, s1);
    a_in = 16'h4000; b_in = 16'h0123; ci_in = 1'b1;
    @(negedge clk); chk("b2b.t4_busy", 16'(busy0), 16'd1);
    chk("b2b.t4_done", 16'(done0), 16'd0);
    start0 = 1'b0;
    @(negedge clk); chk("b2b.t5_done", 16'(done0), 16'd0);
    @(negedge clk); chk("b2b.t6_done", 16'(done0), 16'd1);
    chk("b2b.sum2", sum0, s2);
    prev_sum0 = s2;

    // Reset asserted during HI aborts the operation
    @(negedge clk);
    a_in = 16'h7777; b_in = 16'h1111; ci_in = 1'b1; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); chk("rst_hi.in_hi", 16'(busy0), 16'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sel2 = 1'b0; #1 chk_zero("rst_hi");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hi.no_done", 16'(done0), 16'd0);
      chk("rst_hi.idle", 16'(busy0), 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
